// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the router input-path controller.
//   state_e      - FSM state encoding (binary; all 8 codes are legal states)
//   NUM_PORTS    - number of router output ports
//   ADDR_INVALID - header address that selects no port
//   sel_port()   - picks one per-port flag by a 2-bit port address
package router_pkg;

  localparam int         NUM_PORTS    = 3;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_DA  = 3'd0,  // DECODE_ADDRESS
    ST_LFD = 3'd1,  // LOAD_FIRST_DATA
    ST_LD  = 3'd2,  // LOAD_DATA
    ST_FFS = 3'd3,  // FIFO_FULL_STATE
    ST_LAF = 3'd4,  // LOAD_AFTER_FULL
    ST_LP  = 3'd5,  // LOAD_PARITY
    ST_CPE = 3'd6,  // CHECK_PARITY_ERROR
    ST_WTE = 3'd7   // WAIT_TILL_EMPTY
  } state_e;

  // The invalid address selects nothing, so it reads as 0 (not empty / no soft reset).
  function automatic logic sel_port(input logic [NUM_PORTS-1:0] vec,
                                    input logic [1:0]           addr);
    case (addr)
      2'd0:    sel_port = vec[0];
      2'd1:    sel_port = vec[1];
      2'd2:    sel_port = vec[2];
      default: sel_port = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_fsm_addr_sel.sv
// router_fsm_addr_sel: holds the destination port of the packet in flight and
// routes that port's fifo_empty / soft_reset flags back to the controller.
// Ports:
//   clock, reset       - clock and synchronous active-high reset
//   capture_i          - load data_in_i as the new destination this cycle
//   data_in_i[1:0]     - header address bits
//   fifo_empty_i[2:0]  - per-port FIFO empty flags
//   soft_reset_i[2:0]  - per-port read-timeout soft resets
//   addr_o[1:0]        - latched destination address
//   fifo_empty_sel_o   - empty flag of the latched port
//   soft_reset_sel_o   - soft reset of the latched port
module router_fsm_addr_sel
  import router_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 capture_i,
  input  logic [1:0]           data_in_i,
  input  logic [NUM_PORTS-1:0] fifo_empty_i,
  input  logic [NUM_PORTS-1:0] soft_reset_i,
  output logic [1:0]           addr_o,
  output logic                 fifo_empty_sel_o,
  output logic                 soft_reset_sel_o
);

  logic [1:0] addr_q;
  logic [1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (capture_i) addr_d = data_in_i;
  end

  always_ff @(posedge clock) begin
    if (reset) addr_q <= 2'b00;
    else       addr_q <= addr_d;
  end

  assign addr_o           = addr_q;
  assign fifo_empty_sel_o = sel_port(fifo_empty_i, addr_q);
  assign soft_reset_sel_o = sel_port(soft_reset_i, addr_q);

endmodule

// File: rtl/router_fsm.sv
// router_fsm: controller for the 1x3 router input path. Decodes the header
// address, waits for the target FIFO to drain, sequences payload/parity loads
// into router_register and recovers from FIFO-full and soft-reset events.
// Ports:
//   clock, reset                 - clock, synchronous active-high reset
//   pkt_valid, data_in[1:0]      - source byte valid, header address bits
//   fifo_full                    - full flag of the addressed FIFO
//   fifo_empty_0..2              - per-port FIFO empty flags
//   soft_reset_0..2              - per-port read-timeout soft resets
//   parity_done, low_pkt_valid   - status from router_register
//   write_enb_reg                - FIFO write strobe
//   detect_add .. rst_int_reg    - one-hot state indications to router_register
//   busy                         - source must hold its current byte
module router_fsm
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  state_e               state_q;
  logic [NUM_PORTS-1:0] fifo_empty_vec;
  logic [NUM_PORTS-1:0] soft_reset_vec;
  logic                 hdr_ok;
  logic                 hdr_empty;
  logic                 capture;
  logic [1:0]           addr_q;
  logic                 fifo_empty_sel;
  logic                 soft_reset_sel;

  assign fifo_empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_reset_vec = {soft_reset_2, soft_reset_1, soft_reset_0};

  // In DA the decision uses the header byte itself, not the latched address.
  assign hdr_ok    = pkt_valid && (data_in != ADDR_INVALID);
  assign hdr_empty = sel_port(fifo_empty_vec, data_in);
  assign capture   = (state_q == ST_DA) && hdr_ok;

  router_fsm_addr_sel u_addr_sel (
    .clock            (clock),
    .reset            (reset),
    .capture_i        (capture),
    .data_in_i        (data_in),
    .fifo_empty_i     (fifo_empty_vec),
    .soft_reset_i     (soft_reset_vec),
    .addr_o           (addr_q),
    .fifo_empty_sel_o (fifo_empty_sel),
    .soft_reset_sel_o (soft_reset_sel)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_DA;
    end else if (soft_reset_sel) begin
      // Read timeout on the latched port abandons the packet from any state.
      state_q <= ST_DA;
    end else begin
      case (state_q)
        ST_DA:   if (hdr_ok) state_q <= hdr_empty ? ST_LFD : ST_WTE;
        ST_LFD:  state_q <= ST_LD;
        // fifo_full wins over end-of-packet; the parity byte is then
        // recovered through low_pkt_valid in LAF.
        ST_LD:   if (fifo_full)       state_q <= ST_FFS;
                 else if (!pkt_valid) state_q <= ST_LP;
        ST_FFS:  if (!fifo_full) state_q <= ST_LAF;
        ST_LAF:  if (parity_done)        state_q <= ST_DA;
                 else if (low_pkt_valid) state_q <= ST_LP;
                 else                    state_q <= ST_LD;
        ST_LP:   state_q <= ST_CPE;
        ST_CPE:  state_q <= fifo_full ? ST_FFS : ST_DA;
        ST_WTE:  if (fifo_empty_sel) state_q <= ST_LFD;
        default: state_q <= ST_DA;
      endcase
    end
  end

  assign detect_add    = (state_q == ST_DA);
  assign lfd_state     = (state_q == ST_LFD);
  assign ld_state      = (state_q == ST_LD);
  assign laf_state     = (state_q == ST_LAF);
  assign full_state    = (state_q == ST_FFS);
  assign rst_int_reg   = (state_q == ST_CPE);
  assign write_enb_reg = (state_q == ST_LD) || (state_q == ST_LAF) || (state_q == ST_LP);
  assign busy          = !((state_q == ST_DA) || (state_q == ST_LD));

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: self-checking bench for router_fsm. Each scenario task builds
// a table of per-cycle inputs plus the state expected after the next clock
// edge; the expected output vector is queued when the inputs are driven and
// popped and compared on the following falling edge.
module tb_router_fsm;

  logic       clock, reset, pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_pkt_valid;
  logic       write_enb_reg, detect_add, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg, busy;
  logic [7:0] outs;

  localparam int S_DA = 0, S_LFD = 1, S_LD = 2, S_FFS = 3;
  localparam int S_LAF = 4, S_LP = 5, S_CPE = 6, S_WTE = 7;

  typedef struct {
    bit       rst;
    bit       pv;
    bit [1:0] din;
    bit       ff;
    bit       pd;
    bit       lpv;
    bit [2:0] fe;
    bit [2:0] sr;
    int       st;
  } step_t;

  logic [7:0] sb[$];
  int vectors = 0;
  int miscompares = 0;

  router_fsm dut (
    .clock         (clock),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .write_enb_reg (write_enb_reg),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  assign outs = {write_enb_reg, detect_add, lfd_state, ld_state,
                 laf_state, full_state, rst_int_reg, busy};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Moore output model: {we, detect_add, lfd, ld, laf, full, rst_int, busy}
  function automatic logic [7:0] exp_out(input int st);
    case (st)
      S_DA:    exp_out = 8'b0100_0000;
      S_LFD:   exp_out = 8'b0010_0001;
      S_LD:    exp_out = 8'b1001_0000;
      S_FFS:   exp_out = 8'b0000_0101;
      S_LAF:   exp_out = 8'b1000_1001;
      S_LP:    exp_out = 8'b1000_0001;
      S_CPE:   exp_out = 8'b0000_0011;
      S_WTE:   exp_out = 8'b0000_0001;
      default: exp_out = 8'hxx;
    endcase
  endfunction

  function automatic step_t mk(input int st, input bit pv = 0, input bit [1:0] din = 0,
                               input bit ff = 0, input bit pd = 0, input bit lpv = 0,
                               input bit [2:0] fe = 3'b111, input bit [2:0] sr = 3'b000,
                               input bit rst = 0);
    step_t s;
    s.st = st; s.pv = pv; s.din = din; s.ff = ff; s.pd = pd; s.lpv = lpv;
    s.fe = fe; s.sr = sr; s.rst = rst;
    return s;
  endfunction

  task automatic apply(input step_t s);
    reset = s.rst;
    pkt_valid = s.pv;
    data_in = s.din;
    fifo_full = s.ff;
    parity_done = s.pd;
    low_pkt_valid = s.lpv;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = s.fe;
    {soft_reset_2, soft_reset_1, soft_reset_0} = s.sr;
  endtask

  task automatic test_reset();
    step_t steps[$];
    logic [7:0] got, exp;
    steps.push_back(mk(S_DA, 1, 2'd0, 0, 0, 0, 3'b111, 3'b000, 1));
    steps.push_back(mk(S_DA, 1, 2'd0, 0, 0, 0, 3'b111, 3'b000, 1));
    steps.push_back(mk(S_DA, 0));
    // reset must also win over an in-flight packet and fifo_full
    steps.push_back(mk(S_LFD, 1, 2'd0));
    steps.push_back(mk(S_LD, 1));
    steps.push_back(mk(S_DA, 1, 2'd0, 1, 0, 0, 3'b111, 3'b000, 1));
    steps.push_back(mk(S_DA, 0));
    foreach (steps[i]) begin
      apply(steps[i]);
      sb.push_back(exp_out(steps[i].st));
      @(posedge clock);
      @(negedge clock);
      got = outs;
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset step %0d: outputs %b, required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_normal();
    step_t steps[$];
    logic [7:0] got, exp;
    int we_cnt = 0;
    int rst_int_cnt = 0;
    steps.push_back(mk(S_LFD, 1, 2'd2));
    steps.push_back(mk(S_LD, 1, 2'd2));
    for (int k = 0; k < 17; k++) steps.push_back(mk(S_LD, 1, 2'd2));
    steps.push_back(mk(S_LP, 0));
    steps.push_back(mk(S_CPE, 0));
    steps.push_back(mk(S_DA, 0));
    foreach (steps[i]) begin
      apply(steps[i]);
      sb.push_back(exp_out(steps[i].st));
      @(posedge clock);
      @(negedge clock);
      got = outs;
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL normal step %0d: outputs %b, required %b", i, got, exp);
      end
      if (got[7] === 1'b1) we_cnt++;
      if (got[1] === 1'b1) rst_int_cnt++;
    end
    vectors++;
    if (we_cnt !== 19) begin
      miscompares++;
      $display("FAIL normal write_enb_cycles: got %0d, required 19", we_cnt);
    end
    vectors++;
    if (rst_int_cnt !== 1) begin
      miscompares++;
      $display("FAIL normal rst_int_pulses: got %0d, required 1", rst_int_cnt);
    end
  endtask

  task automatic test_busy_target();
    step_t steps[$];
    logic [7:0] got, exp;
    // only port 1 is non-empty, so a wrong port select leaves WTE early
    for (int k = 0; k < 5; k++) steps.push_back(mk(S_WTE, 1, 2'd1, 0, 0, 0, 3'b101));
    steps.push_back(mk(S_LFD, 1, 2'd1));
    steps.push_back(mk(S_LD, 1));
    steps.push_back(mk(S_LP, 0));
    steps.push_back(mk(S_CPE, 0));
    steps.push_back(mk(S_DA, 0));
    foreach (steps[i]) begin
      apply(steps[i]);
      sb.push_back(exp_out(steps[i].st));
      @(posedge clock);
      @(negedge clock);
      got = outs;
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL busy_target step %0d: outputs %b, required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_fifo_full();
    step_t steps[$];
    logic [7:0] got, exp;
    steps.push_back(mk(S_LFD, 1, 2'd0));
    steps.push_back(mk(S_LD, 1));
    steps.push_back(mk(S_LD, 1));
    steps.push_back(mk(S_FFS, 0, 2'd0, 1));        // full beats !pkt_valid
    steps.push_back(mk(S_FFS, 0, 2'd0, 1));
    steps.push_back(mk(S_FFS, 0, 2'd0, 1));
    steps.push_back(mk(S_LAF, 0));
    steps.push_back(mk(S_LD, 1));                  // LAF, no parity / low_pkt
    steps.push_back(mk(S_FFS, 1, 2'd0, 1));
    steps.push_back(mk(S_LAF, 1));
    steps.push_back(mk(S_LP, 0, 2'd0, 0, 0, 1));   // LAF with low_pkt_valid
    steps.push_back(mk(S_CPE, 0));
    steps.push_back(mk(S_FFS, 0, 2'd0, 1));        // CPE with fifo_full
    steps.push_back(mk(S_LAF, 0));
    steps.push_back(mk(S_DA, 0, 2'd0, 0, 1, 1));   // parity_done beats low_pkt_valid
    foreach (steps[i]) begin
      apply(steps[i]);
      sb.push_back(exp_out(steps[i].st));
      @(posedge clock);
      @(negedge clock);
      got = outs;
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL fifo_full step %0d: outputs %b, required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_soft_reset();
    step_t steps[$];
    logic [7:0] got, exp;
    steps.push_back(mk(S_LFD, 1, 2'd0));
    steps.push_back(mk(S_LD, 1));
    steps.push_back(mk(S_LD, 1, 2'd0, 0, 0, 0, 3'b111, 3'b010));  // other port: ignored
    steps.push_back(mk(S_DA, 1, 2'd0, 0, 0, 0, 3'b111, 3'b001));  // own port: abort
    steps.push_back(mk(S_DA, 0));
    steps.push_back(mk(S_WTE, 1, 2'd2, 0, 0, 0, 3'b011));
    steps.push_back(mk(S_WTE, 1, 2'd2, 0, 0, 0, 3'b011, 3'b001));
    steps.push_back(mk(S_DA, 1, 2'd2, 0, 0, 0, 3'b011, 3'b100));  // abort from WTE
    steps.push_back(mk(S_DA, 1, 2'd2, 0, 0, 0, 3'b111, 3'b100));  // held in DA
    steps.push_back(mk(S_DA, 0));
    foreach (steps[i]) begin
      apply(steps[i]);
      sb.push_back(exp_out(steps[i].st));
      @(posedge clock);
      @(negedge clock);
      got = outs;
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL soft_reset step %0d: outputs %b, required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_invalid_addr();
    step_t steps[$];
    logic [7:0] got, exp;
    for (int k = 0; k < 4; k++) steps.push_back(mk(S_DA, 1, 2'd3));
    steps.push_back(mk(S_DA, 0));
    // back-to-back: valid header straight after, to a non-empty port 0
    steps.push_back(mk(S_WTE, 1, 2'd0, 0, 0, 0, 3'b110));
    steps.push_back(mk(S_LFD, 1, 2'd0, 0, 0, 0, 3'b111));
    steps.push_back(mk(S_LD, 1));
    steps.push_back(mk(S_LP, 0));
    steps.push_back(mk(S_CPE, 0));
    steps.push_back(mk(S_DA, 0));
    foreach (steps[i]) begin
      apply(steps[i]);
      sb.push_back(exp_out(steps[i].st));
      @(posedge clock);
      @(negedge clock);
      got = outs;
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL invalid_addr step %0d: outputs %b, required %b", i, got, exp);
      end
    end
  endtask

  initial begin
    apply(mk(S_DA, 0, 2'd0, 0, 0, 0, 3'b111, 3'b000, 1));
    test_reset();
    test_normal();
    test_busy_target();
    test_fifo_full();
    test_soft_reset();
    test_invalid_addr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Controller for the 1x3 router input path; sits directly upstream of router_register and drives its control inputs.
- Outputs: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg.
- Also produces write_enb_reg (FIFO write strobe) and busy (back-pressure to the packet source).
- Decodes the 2-bit destination in the header, waits for the target FIFO to drain, sequences payload and parity loading, and recovers from FIFO-full and soft-reset events.

Parameters:
none (3 output ports fixed; address 2'b11 is invalid)

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
pkt_valid  input  1  packet byte valid from source; deasserted on the parity byte
data_in  input  2  header address bits (data_in[1:0] of the input byte)
fifo_full  input  1  full flag of the currently addressed FIFO
fifo_empty_0  input  1  FIFO 0 empty
fifo_empty_1  input  1  FIFO 1 empty
fifo_empty_2  input  1  FIFO 2 empty
soft_reset_0  input  1  read-timeout soft reset, port 0
soft_reset_1  input  1  read-timeout soft reset, port 1
soft_reset_2  input  1  read-timeout soft reset, port 2
parity_done  input  1  from router_register: parity byte captured
low_pkt_valid  input  1  from router_register: pkt_valid fell while FIFO was full
write_enb_reg  output  1  FIFO write enable
detect_add  output  1  in DECODE_ADDRESS
lfd_state  output  1  in LOAD_FIRST_DATA
ld_state  output  1  in LOAD_DATA
laf_state  output  1  in LOAD_AFTER_FULL
full_state  output  1  in FIFO_FULL_STATE
rst_int_reg  output  1  in CHECK_PARITY_ERROR
busy  output  1  source must hold the current byte

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- States: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE), WAIT_TILL_EMPTY (WTE).
- Reset state: DA. Latched address = 2'b00.
- Registered address:
  - Captured from data_in whenever state==DA && pkt_valid && data_in!=2'b11.
  - Held through the packet.
  - Selects the fifo_empty_x / soft_reset_x used in all later states.
- Transitions (next state):
  - DA: pkt_valid && addr!=3 && fifo_empty[addr] -> LFD; pkt_valid && addr!=3 && !fifo_empty[addr] -> WTE; otherwise stay. Address 3 is ignored and no write occurs.
  - LFD -> LD (unconditional, 1 cycle).
  - LD: fifo_full -> FFS; else !pkt_valid -> LP; else stay. fifo_full has priority.
  - FFS: !fifo_full -> LAF; else stay.
  - LAF: parity_done -> DA; else low_pkt_valid -> LP; else -> LD.
  - LP -> CPE (unconditional).
  - CPE: fifo_full -> FFS; else -> DA.
  - WTE: fifo_empty[latched addr] -> LFD; else stay.
- Priority: reset > soft_reset[latched addr] > normal transitions. Soft reset from any state forces DA on the next edge.
- Soft reset of a non-selected port has no effect.
- Soft reset in DA has no effect beyond remaining in DA.
- Outputs are Moore (decoded from current state), combinational from the state register. All are 0 except as listed:
  - detect_add = DA
  - lfd_state = LFD
  - ld_state = LD
  - laf_state = LAF
  - full_state = FFS
  - rst_int_reg = CPE
  - write_enb_reg = LD | LAF | LP
  - busy = LFD | FFS | LAF | LP | CPE | WTE (busy=0 in DA and LD)
- Reset values: detect_add=1; all other outputs 0.
- Latency: header accepted in DA at cycle 0 -> LFD at cycle 1 -> LD at cycle 2; first payload write_enb_reg=1 at cycle 2.
- Simultaneous fifo_full and !pkt_valid in LD -> FFS. The parity byte is handled via low_pkt_valid in LAF.
- State encoding: one-hot or binary, implementer's choice. Illegal state -> DA.

Decomposition:
- Package router_pkg:
  - state enum/localparams (DA..WTE)
  - ADDR_INVALID = 2'b11
  - NUM_PORTS = 3
- Sub-module router_fsm_addr_sel: latched-address register plus 3:1 mux of fifo_empty_x and soft_reset_x. Everything else stays in router_fsm.

Test Plan:
- Reset: reset=1 for 2 cycles -> detect_add=1, busy=0, write_enb_reg=0; state DA after release.
- Normal packet: addr=2'b10, fifo_empty_2=1, pkt_valid held 18 payload cycles then dropped -> sequence DA,LFD,LD×18,LP,CPE,DA. write_enb_reg=1 for 19 cycles (LD+LP). rst_int_reg pulses 1 cycle.
- Busy target: addr=2'b01, fifo_empty_1=0 for 5 cycles then 1 -> WTE for 5 cycles with busy=1, then LFD, LD.
- FIFO full mid-packet: in LD assert fifo_full 3 cycles -> FFS 3 cycles (busy=1, write_enb_reg=0). Then LAF with low_pkt_valid=0, parity_done=0 -> LD. Repeat with low_pkt_valid=1 -> LP. Repeat with parity_done=1 -> DA.
- Soft reset: in LD for addr 0, assert soft_reset_1 -> no effect. Assert soft_reset_0 -> DA next cycle, detect_add=1.
- Invalid address: pkt_valid=1, data_in=2'b11 for 4 cycles -> remains DA, write_enb_reg=0, busy=0.
